// File: rtl/pp_game_pkg.sv
// pp_game_pkg
//   Shared constants for the second-generation ping-pong game controller:
//   FSM state encodings, player side codes and winner codes.
//   No ports; imported by pp_score_keeper and pp_game_ctrl_gen2.
package pp_game_pkg;

   typedef logic [2:0] state_t;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FLY_R = 3'd1;   // ball travelling toward P2 (>>1)
   localparam logic [2:0] ST_FLY_L = 3'd2;   // ball travelling toward P1 (<<1)
   localparam logic [2:0] ST_POINT = 3'd3;
   localparam logic [2:0] ST_OVER  = 3'd4;

   localparam logic SIDE_P1 = 1'b0;
   localparam logic SIDE_P2 = 1'b1;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;

   function automatic logic [1:0] winner_code(input logic side);
      return (side == SIDE_P2) ? WIN_P2 : WIN_P1;
   endfunction

endpackage

// File: rtl/pp_score_keeper.sv
// pp_score_keeper
//   Owns both score counters, serve rotation, deuce detection and the win decision.
//   Ports:
//     clk, rst          clock, synchronous active-low reset
//     point_en          one-cycle strobe: award a point this cycle
//     point_side        side receiving the point (SIDE_P1 / SIDE_P2)
//     score_p1/p2       saturating score counters
//     serve_side        side serving next
//     win               combinational: the point being awarded now wins the game
//     winner            registered winner code, held until reset
module pp_score_keeper
   import pp_game_pkg::*;
#(
   parameter int WIN_SCORE = 11,
   parameter int SCORE_W   = 5,
   parameter int DEUCE_EN  = 1,
   parameter int SERVE_ROT = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               point_en,
   input  logic               point_side,
   output logic [SCORE_W-1:0] score_p1,
   output logic [SCORE_W-1:0] score_p2,
   output logic               serve_side,
   output logic               win,
   output logic [1:0]         winner
);

   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
   localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
   localparam logic [SCORE_W-1:0] DEUCE_VAL = SCORE_W'(WIN_SCORE - 1);
   localparam int                 ROT_W     = (SERVE_ROT > 1) ? $clog2(SERVE_ROT) : 1;
   localparam logic [ROT_W-1:0]   ROT_LAST  = ROT_W'(SERVE_ROT - 1);

   logic [SCORE_W-1:0] nxt_p1, nxt_p2;
   logic [SCORE_W-1:0] sc, ot;          // scorer / opponent after this point
   logic [ROT_W-1:0]   rot_cnt;         // points played in the current serve turn
   logic               deuce;

   // NOTE: every signal gets a default first, so no path can leave one unassigned (no latch).
   always_comb begin
      nxt_p1 = score_p1;
      nxt_p2 = score_p2;
      if (point_side == SIDE_P1) begin
         if (score_p1 != SCORE_MAX) nxt_p1 = score_p1 + 1'b1;
      end else begin
         if (score_p2 != SCORE_MAX) nxt_p2 = score_p2 + 1'b1;
      end
      sc    = (point_side == SIDE_P1) ? nxt_p1 : nxt_p2;
      ot    = (point_side == SIDE_P1) ? nxt_p2 : nxt_p1;
      // Deuce is judged on the post-point score so the point that reaches it already
      // rotates serve every point.
      deuce = (DEUCE_EN != 0) && (nxt_p1 >= DEUCE_VAL) && (nxt_p2 >= DEUCE_VAL);
      win   = point_en &&
              ((sc == SCORE_MAX) ||
               ((sc >= WIN_VAL) && ((DEUCE_EN == 0) || ((sc > ot) && ((sc - ot) >= SCORE_W'(2))))));
   end

   // NOTE: sequential state uses <= so every flop samples the pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         score_p1   <= '0;
         score_p2   <= '0;
         serve_side <= SIDE_P1;
         rot_cnt    <= '0;
         winner     <= WIN_NONE;
      end else if (point_en) begin
         score_p1 <= nxt_p1;
         score_p2 <= nxt_p2;
         if (deuce || (rot_cnt == ROT_LAST)) begin
            serve_side <= ~serve_side;
            rot_cnt    <= '0;
         end else begin
            rot_cnt <= rot_cnt + 1'b1;
         end
         if (win) winner <= winner_code(point_side);
      end
   end

endmodule

// File: rtl/pp_game_ctrl_gen2.sv
// pp_game_ctrl_gen2
//   Ping-pong game controller for the LED-track game box: rally FSM, ball position
//   shifter, tick divider with rally speed-up, and the score keeper.
//   Ports:
//     clk, rst              clock, synchronous active-low reset
//     tick_en               one-cycle ball-step strobe
//     key_p1_eff/p2_eff     debounced keys, active low, one-cycle pulses
//     position              one-hot ball position (0 = no ball), P1 end = MSB
//     score_p1/p2           scores
//     serve_side            0 = P1 serves next, 1 = P2
//     point_pulse           one cycle, the cycle after a point is scored
//     game_over             high while the game is over
//     winner                00 none, 01 P1, 10 P2
module pp_game_ctrl_gen2
   import pp_game_pkg::*;
#(
   parameter int TRACK_LEN    = 8,
   parameter int HIT_ZONE     = 4,
   parameter int WIN_SCORE    = 11,
   parameter int SCORE_W      = 5,
   parameter int DEUCE_EN     = 1,
   parameter int SERVE_ROT    = 2,
   parameter int BASE_DIV     = 4,
   parameter int SPEEDUP_HITS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick_en,
   input  logic                 key_p1_eff,
   input  logic                 key_p2_eff,
   output logic [TRACK_LEN-1:0] position,
   output logic [SCORE_W-1:0]   score_p1,
   output logic [SCORE_W-1:0]   score_p2,
   output logic                 serve_side,
   output logic                 point_pulse,
   output logic                 game_over,
   output logic [1:0]           winner
);

   localparam int DIV_W   = $clog2(BASE_DIV + 1);
   localparam int RALLY_W = 16;
   localparam int SPD_MOD = (SPEEDUP_HITS > 0) ? SPEEDUP_HITS : 1;

   localparam logic [TRACK_LEN-1:0] END_P2  = TRACK_LEN'(1);
   localparam logic [TRACK_LEN-1:0] END_P1  = END_P2 << (TRACK_LEN - 1);
   localparam logic [TRACK_LEN-1:0] ZONE_P2 = {{(TRACK_LEN - HIT_ZONE){1'b0}}, {HIT_ZONE{1'b1}}};
   localparam logic [TRACK_LEN-1:0] ZONE_P1 = ZONE_P2 << (TRACK_LEN - HIT_ZONE);

   state_t               state;
   logic [DIV_W-1:0]     div, tick_cnt;
   logic [RALLY_W-1:0]   rally_cnt, rally_nxt;
   logic [TRACK_LEN-1:0] zone, rx_end;
   logic                 fly_r, hitter, rx_press, serve_press;
   logic                 in_zone, at_end, step_due, speed_up;
   logic                 point_en, point_side, win;

   always_comb begin
      fly_r       = (state == ST_FLY_R);
      hitter      = fly_r ? SIDE_P1 : SIDE_P2;
      // Only the role-valid key is ever looked at; the other one is simply not decoded.
      rx_press    = fly_r ? !key_p2_eff : !key_p1_eff;
      serve_press = (serve_side == SIDE_P1) ? !key_p1_eff : !key_p2_eff;
      zone        = fly_r ? ZONE_P2 : ZONE_P1;
      rx_end      = fly_r ? END_P2 : END_P1;
      in_zone     = |(position & zone);
      at_end      = (position == rx_end);
      step_due    = tick_en && (tick_cnt == div - 1'b1);
      rally_nxt   = (rally_cnt == '1) ? rally_cnt : rally_cnt + 1'b1;
      speed_up    = (SPEEDUP_HITS > 0) && ((32'(rally_nxt) % SPD_MOD) == 0);
      point_en    = (state == ST_POINT);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= ST_IDLE;
         position    <= '0;
         div         <= DIV_W'(BASE_DIV);
         tick_cnt    <= '0;
         rally_cnt   <= '0;
         point_side  <= SIDE_P1;
         point_pulse <= 1'b0;
      end else begin
         point_pulse <= point_en;
         case (state)
            ST_IDLE: begin
               if (serve_press) begin
                  state    <= (serve_side == SIDE_P1) ? ST_FLY_R : ST_FLY_L;
                  position <= (serve_side == SIDE_P1) ? END_P1 : END_P2;
                  tick_cnt <= '0;
                  div      <= DIV_W'(BASE_DIV);
               end
            end
            ST_FLY_R, ST_FLY_L: begin
               // A press is judged on the pre-shift position and outranks a due step/miss.
               if (rx_press) begin
                  if (in_zone) begin
                     state     <= fly_r ? ST_FLY_L : ST_FLY_R;
                     tick_cnt  <= '0;
                     rally_cnt <= rally_nxt;
                     if (speed_up && (div > DIV_W'(1))) div <= div - 1'b1;
                  end else begin
                     state      <= ST_POINT;
                     position   <= '0;
                     point_side <= hitter;
                  end
               end else if (tick_en) begin
                  if (step_due) begin
                     tick_cnt <= '0;
                     if (at_end) begin
                        state      <= ST_POINT;
                        position   <= '0;
                        point_side <= hitter;
                     end else begin
                        position <= fly_r ? (position >> 1) : (position << 1);
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            ST_POINT: begin
               rally_cnt <= '0;
               state     <= win ? ST_OVER : ST_IDLE;
            end
            ST_OVER: ;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign game_over = (state == ST_OVER);

   pp_score_keeper #(
      .WIN_SCORE (WIN_SCORE),
      .SCORE_W   (SCORE_W),
      .DEUCE_EN  (DEUCE_EN),
      .SERVE_ROT (SERVE_ROT)
   ) u_score (
      .clk        (clk),
      .rst        (rst),
      .point_en   (point_en),
      .point_side (point_side),
      .score_p1   (score_p1),
      .score_p2   (score_p2),
      .serve_side (serve_side),
      .win        (win),
      .winner     (winner)
   );

endmodule

// File: tb/tb_pp_game_ctrl_gen2.sv
`timescale 1ns/1ps
module tb_pp_game_ctrl_gen2;
   import pp_game_pkg::*;

   localparam int TRACK_LEN    = 8;
   localparam int HIT_ZONE     = 4;
   localparam int WIN_SCORE    = 11;
   localparam int SCORE_W      = 5;
   localparam int DEUCE_EN     = 1;
   localparam int SERVE_ROT    = 2;
   localparam int BASE_DIV     = 4;
   localparam int SPEEDUP_HITS = 4;
   localparam int SMAX         = (1 << SCORE_W) - 1;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 tick_en = 1'b0;
   logic                 key_p1_eff = 1'b1;
   logic                 key_p2_eff = 1'b1;
   logic [TRACK_LEN-1:0] position;
   logic [SCORE_W-1:0]   score_p1, score_p2;
   logic                 serve_side, point_pulse, game_over;
   logic [1:0]           winner;

   always #5 clk = ~clk;

   pp_game_ctrl_gen2 #(
      .TRACK_LEN(TRACK_LEN), .HIT_ZONE(HIT_ZONE), .WIN_SCORE(WIN_SCORE), .SCORE_W(SCORE_W),
      .DEUCE_EN(DEUCE_EN), .SERVE_ROT(SERVE_ROT), .BASE_DIV(BASE_DIV), .SPEEDUP_HITS(SPEEDUP_HITS)
   ) dut (
      .clk(clk), .rst(rst), .tick_en(tick_en), .key_p1_eff(key_p1_eff), .key_p2_eff(key_p2_eff),
      .position(position), .score_p1(score_p1), .score_p2(score_p2), .serve_side(serve_side),
      .point_pulse(point_pulse), .game_over(game_over), .winner(winner)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard of expected post-point state, pushed when a point is played.
   typedef struct {
      logic [SCORE_W-1:0] s1;
      logic [SCORE_W-1:0] s2;
      logic               serve;
      logic [1:0]         win;
      logic               over;
   } exp_t;
   exp_t exp_q[$];

   int         m_s1, m_s2, m_rot;
   logic       m_serve, m_over;
   logic [1:0] m_win;

   task automatic model_point(input logic side);
      int  sc, ot;
      bit  deuce;
      if (side == SIDE_P1) begin
         if (m_s1 < SMAX) m_s1++;
      end else if (m_s2 < SMAX) m_s2++;
      deuce = (DEUCE_EN != 0) && (m_s1 >= WIN_SCORE - 1) && (m_s2 >= WIN_SCORE - 1);
      if (deuce || (m_rot == SERVE_ROT - 1)) begin
         m_serve = ~m_serve;
         m_rot   = 0;
      end else m_rot++;
      sc = (side == SIDE_P1) ? m_s1 : m_s2;
      ot = (side == SIDE_P1) ? m_s2 : m_s1;
      if ((sc == SMAX) || ((sc >= WIN_SCORE) && ((DEUCE_EN == 0) || (sc - ot >= 2)))) begin
         m_over = 1'b1;
         m_win  = (side == SIDE_P1) ? 2'b01 : 2'b10;
      end
      exp_q.push_back('{SCORE_W'(m_s1), SCORE_W'(m_s2), m_serve, m_win, m_over});
   endtask

   // One clock: drive inputs, take the edge, sample 1 ns later, release pulses.
   task automatic cyc(input logic k1, input logic k2, input logic tk);
      key_p1_eff = k1;
      key_p2_eff = k2;
      tick_en    = tk;
      @(posedge clk);
      #1;
      key_p1_eff = 1'b1;
      key_p2_eff = 1'b1;
      tick_en    = 1'b0;
   endtask

   task automatic press(input logic side, input logic tk);
      if (side == SIDE_P1) cyc(1'b0, 1'b1, tk);
      else                 cyc(1'b1, 1'b0, tk);
   endtask

   task automatic tick_until(input logic [TRACK_LEN-1:0] target);
      for (int i = 0; i < 200 && position !== target; i++) cyc(1'b1, 1'b1, 1'b1);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      cyc(1'b1, 1'b1, 1'b0);
      rst     = 1'b1;
      m_s1    = 0;
      m_s2    = 0;
      m_rot   = 0;
      m_serve = SIDE_P1;
      m_over  = 1'b0;
      m_win   = 2'b00;
      exp_q.delete();
   endtask

   task automatic check_zero(input string tag);
      check($sformatf("%s position", tag), 32'(position), 32'h0);
      check($sformatf("%s score_p1", tag), 32'(score_p1), 32'h0);
      check($sformatf("%s score_p2", tag), 32'(score_p2), 32'h0);
      check($sformatf("%s serve_side", tag), 32'(serve_side), 32'h0);
      check($sformatf("%s point_pulse", tag), 32'(point_pulse), 32'h0);
      check($sformatf("%s game_over", tag), 32'(game_over), 32'h0);
      check($sformatf("%s winner", tag), 32'(winner), 32'h0);
   endtask

   // Wait (bounded) for point_pulse, then pop and compare the scoreboard entry.
   task automatic wait_point(input string tag);
      exp_t e;
      for (int i = 0; i < 64 && point_pulse !== 1'b1; i++) cyc(1'b1, 1'b1, 1'b0);
      e = exp_q.pop_front();
      if (point_pulse !== 1'b1) begin
         check($sformatf("%s point_pulse timeout", tag), 32'(point_pulse), 32'h1);
      end else begin
         check($sformatf("%s score_p1", tag), 32'(score_p1), 32'(e.s1));
         check($sformatf("%s score_p2", tag), 32'(score_p2), 32'(e.s2));
         check($sformatf("%s serve_side", tag), 32'(serve_side), 32'(e.serve));
         check($sformatf("%s winner", tag), 32'(winner), 32'(e.win));
         check($sformatf("%s game_over", tag), 32'(game_over), 32'(e.over));
      end
   endtask

   // Play one point won by 'win_side', served by whoever the model says serves.
   task automatic play_point(input logic win_side, input string tag);
      logic srv;
      srv = m_serve;
      press(srv, 1'b0);
      if (win_side == srv) begin
         press(~srv, 1'b0);                    // receiver presses at far end: fault
      end else begin
         tick_until((srv == SIDE_P1) ? 8'h01 : 8'h80);
         press(~srv, 1'b0);                    // legal return on the end LED
         press(srv, 1'b0);                     // server now faults outside its zone
      end
      model_point(win_side);
      wait_point(tag);
   endtask

   typedef struct {
      logic       k1;
      logic       k2;
      logic       tk;
      logic [7:0] pos;
      logic       pulse;
      logic [4:0] s1;
   } vec_t;
   vec_t vecs[14];

   int n;
   int exp_div;

   initial begin
      // inputs (k1,k2,tick) -> expected (position, point_pulse, score_p1) after the edge
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0};  // P2 key in IDLE ignored
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h80, 1'b0, 5'd0};  // P1 serves
      vecs[2]  = '{1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 5'd0};
      vecs[3]  = '{1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 5'd0};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h80, 1'b0, 5'd0};  // hitter key ignored
      vecs[5]  = '{1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 5'd0};
      vecs[6]  = '{1'b1, 1'b1, 1'b1, 8'h40, 1'b0, 5'd0};  // 4th tick steps
      vecs[7]  = '{1'b0, 1'b1, 1'b1, 8'h40, 1'b0, 5'd0};
      vecs[8]  = '{1'b1, 1'b1, 1'b1, 8'h40, 1'b0, 5'd0};
      vecs[9]  = '{1'b1, 1'b1, 1'b1, 8'h40, 1'b0, 5'd0};
      vecs[10] = '{1'b1, 1'b1, 1'b1, 8'h20, 1'b0, 5'd0};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0};  // P2 press at 0x20: fault
      vecs[12] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 5'd1};  // P1 scores, pulse
      vecs[13] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 5'd1};  // pulse lasts one cycle

      // Reset state
      do_reset();
      check_zero("reset");

      // Table: serve, stepping, ignored keys, fault outside zone
      foreach (vecs[i]) begin
         cyc(vecs[i].k1, vecs[i].k2, vecs[i].tk);
         check($sformatf("vec%0d position", i), 32'(position), 32'(vecs[i].pos));
         check($sformatf("vec%0d point_pulse", i), 32'(point_pulse), 32'(vecs[i].pulse));
         check($sformatf("vec%0d score_p1", i), 32'(score_p1), 32'(vecs[i].s1));
      end
      m_s1  = 1;
      m_rot = 1;

      // No return: ball walks to 0x01 in 7*BASE_DIV ticks, then misses
      press(SIDE_P1, 1'b0);
      n = 0;
      while (position !== 8'h01 && n < 100) begin
         cyc(1'b1, 1'b1, 1'b1);
         n++;
      end
      check("miss travel ticks", 32'(n), 32'(7 * BASE_DIV));
      for (int i = 0; i < BASE_DIV - 1; i++) cyc(1'b1, 1'b1, 1'b1);
      check("miss held on end LED", 32'(position), 32'h01);
      cyc(1'b1, 1'b1, 1'b1);
      check("miss position cleared", 32'(position), 32'h00);
      model_point(SIDE_P1);
      wait_point("miss");
      cyc(1'b1, 1'b1, 1'b0);
      check("miss pulse one cycle", 32'(point_pulse), 32'h0);

      // Legal return at 0x08 coinciding with a due step; then ball flies back and P1 misses
      do_reset();
      press(SIDE_P1, 1'b0);
      tick_until(8'h08);
      for (int i = 0; i < BASE_DIV - 1; i++) cyc(1'b1, 1'b1, 1'b1);
      press(SIDE_P2, 1'b1);
      check("return held position", 32'(position), 32'h08);
      check("return rally", 32'(dut.rally_cnt), 32'h1);
      for (int i = 0; i < BASE_DIV; i++) cyc(1'b1, 1'b1, 1'b1);
      check("return reversed", 32'(position), 32'h10);
      tick_until(8'h80);
      for (int i = 0; i < BASE_DIV; i++) cyc(1'b1, 1'b1, 1'b1);
      model_point(SIDE_P2);
      wait_point("p1 miss");

      // Speed-up: step spacing per flight after f legal returns
      do_reset();
      press(SIDE_P1, 1'b0);
      for (int f = 0; f <= 8; f++) begin
         logic [7:0] start;
         exp_div = BASE_DIV - f / SPEEDUP_HITS;
         if (exp_div < 1) exp_div = 1;
         start = position;
         n = 0;
         while (position === start && n < 20) begin
            cyc(1'b1, 1'b1, 1'b1);
            n++;
         end
         check($sformatf("step spacing flight %0d", f), 32'(n), 32'(exp_div));
         if (f < 8) begin
            tick_until((f % 2 == 0) ? 8'h01 : 8'h80);
            press((f % 2 == 0) ? SIDE_P2 : SIDE_P1, 1'b0);
         end
      end
      check("speedup rally", 32'(dut.rally_cnt), 32'h8);
      press(SIDE_P2, 1'b0);                     // P2 fault at 0x40
      model_point(SIDE_P1);
      wait_point("speedup end");

      // Deuce: 10:10 by alternating points, then 11:10 (no win), 12:10 (P1 wins)
      do_reset();
      for (int p = 0; p < 20; p++) play_point((p % 2 == 0) ? SIDE_P1 : SIDE_P2, $sformatf("pt%0d", p));
      play_point(SIDE_P1, "11:10");
      play_point(SIDE_P1, "12:10");
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1);
      check("over position", 32'(position), 32'h00);
      check("over score_p1", 32'(score_p1), 32'd12);
      check("over score_p2", 32'(score_p2), 32'd10);
      check("over game_over", 32'(game_over), 32'h1);
      check("over winner", 32'(winner), 32'h1);
      check("over point_pulse", 32'(point_pulse), 32'h0);

      // Reset mid-flight at 0x10 with P2 serving and a non-zero score
      do_reset();
      play_point(SIDE_P1, "pre1");
      play_point(SIDE_P1, "pre2");
      press(SIDE_P2, 1'b0);
      tick_until(8'h10);
      check("midflight position", 32'(position), 32'h10);
      rst = 1'b0;
      cyc(1'b0, 1'b0, 1'b1);
      rst = 1'b1;
      check_zero("midflight reset");
      cyc(1'b1, 1'b1, 1'b1);
      check("post reset idle position", 32'(position), 32'h00);
      check("scoreboard drained", 32'(exp_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
